// File: rtl/axi_burst_master_p.sv
// axi_burst_master_p: turns one user request (addr, len, strobe, dir) into a
// single AXI4 INCR write or read burst, with AXI3/AXI4 length width, read
// backpressure from the user side and response-error reporting.
// Build option: define AXIBM_4K_SPLIT_EN to split 4KB-crossing requests into
// two bursts; without it such requests are rejected with status 11.
module axi_burst_master_p #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // user side
  input  logic                  user_start,
  input  logic                  user_w_r,
  input  logic [ADDR_W-1:0]     user_addr_in,
  input  logic [LEN_W-1:0]      user_burst_len_in,
  input  logic [DATA_W/8-1:0]   user_data_strb,
  input  logic [DATA_W-1:0]     user_data_in,
  output logic                  user_stall_w_data,
  input  logic                  user_stall_r_data,
  output logic [DATA_W-1:0]     user_data_out,
  output logic                  user_data_out_en,
  output logic                  user_free,
  output logic [1:0]            user_status,
  // write address channel
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [LEN_W-1:0]      m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // write data channel
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // write response channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // read address channel
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [LEN_W-1:0]      m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // read data channel
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SZ     = $clog2(STRB_W);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_RESP = 3'd3;
  localparam logic [2:0] R_ADDR = 3'd4;
  localparam logic [2:0] R_DATA = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [STRB_W-1:0] strb_q;
  logic [LEN_W:0]    beat_cnt;
  logic              err_q;
  logic [1:0]        status_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_out_en_q;

  // Request decode: beat-aligned start address and 4KB page of the last byte.
  logic [ADDR_W-1:0]  addr_al;
  logic [ADDR_W:0]    span;
  logic [ADDR_W-12:0] end_page;
  logic               crossing;

  assign addr_al  = user_addr_in & ~ADDR_W'(STRB_W - 1);
  assign span     = ((ADDR_W+1)'(user_burst_len_in) + (ADDR_W+1)'(1)) << SZ;
  assign end_page = (ADDR_W-11)'(((ADDR_W+1)'(addr_al) + span - (ADDR_W+1)'(1)) >> 12);
  assign crossing = end_page != {1'b0, addr_al[ADDR_W-1:12]};

`ifdef AXIBM_4K_SPLIT_EN
  // First segment runs to the end of the current page, second starts on the next.
  logic [12:0]       first_beats;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [ADDR_W-1:0] addr1;
  logic              seg2_q;
  logic [LEN_W-1:0]  len1_q;
  logic [ADDR_W-1:0] addr1_q;

  assign first_beats = (13'h1000 - {1'b0, addr_al[11:0]}) >> SZ;
  assign len0        = LEN_W'(first_beats - 13'd1);
  assign len1        = user_burst_len_in - len0 - LEN_W'(1);
  assign addr1       = {addr_al[ADDR_W-1:12] + (ADDR_W-12)'(1), 12'h000};
`endif

  logic wlast;
  logic rd_hs;
  logic wr_err;
  logic rd_err;

  assign wlast  = (state == W_DATA) && (beat_cnt == {1'b0, len_q});
  assign rd_hs  = m_axi_rvalid && m_axi_rready;
  assign wr_err = err_q || (m_axi_bresp != 2'b00);
  assign rd_err = err_q || (m_axi_rresp != 2'b00);

  // Sequencer: request capture, channel handshakes, beat counting, status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      strb_q        <= '0;
      beat_cnt      <= '0;
      err_q         <= 1'b0;
      status_q      <= 2'b00;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
`ifdef AXIBM_4K_SPLIT_EN
      seg2_q        <= 1'b0;
      len1_q        <= '0;
      addr1_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge register values; this default makes the read qualifier a pulse.
      data_out_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (user_start) begin
            strb_q   <= user_data_strb;
            beat_cnt <= '0;
            err_q    <= 1'b0;
`ifdef AXIBM_4K_SPLIT_EN
            addr_q   <= addr_al;
            len_q    <= crossing ? len0 : user_burst_len_in;
            seg2_q   <= crossing;
            len1_q   <= len1;
            addr1_q  <= addr1;
            state    <= user_w_r ? R_ADDR : W_ADDR;
`else
            if (crossing) begin
              status_q <= 2'b11;
            end else begin
              addr_q <= addr_al;
              len_q  <= user_burst_len_in;
              state  <= user_w_r ? R_ADDR : W_ADDR;
            end
`endif
          end
        end
        W_ADDR: if (m_axi_awready) state <= W_DATA;
        W_DATA: begin
          if (m_axi_wready) begin
            beat_cnt <= beat_cnt + (LEN_W+1)'(1);
            if (wlast) state <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi_bvalid) begin
`ifdef AXIBM_4K_SPLIT_EN
            if (seg2_q) begin
              seg2_q   <= 1'b0;
              addr_q   <= addr1_q;
              len_q    <= len1_q;
              beat_cnt <= '0;
              err_q    <= wr_err;
              state    <= W_ADDR;
            end else
`endif
            begin
              status_q <= wr_err ? 2'b10 : 2'b00;
              state    <= IDLE;
            end
          end
        end
        R_ADDR: if (m_axi_arready) state <= R_DATA;
        R_DATA: begin
          if (rd_hs) begin
            data_out_q    <= m_axi_rdata;
            data_out_en_q <= 1'b1;
            err_q         <= rd_err;
            if (m_axi_rlast) begin
`ifdef AXIBM_4K_SPLIT_EN
              if (seg2_q) begin
                seg2_q <= 1'b0;
                addr_q <= addr1_q;
                len_q  <= len1_q;
                state  <= R_ADDR;
              end else
`endif
              begin
                status_q <= rd_err ? 2'b10 : 2'b00;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel outputs are decoded straight from the state; write data passes through.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == W_ADDR);
  assign m_axi_wdata   = user_data_in;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wlast   = wlast;
  assign m_axi_wvalid  = (state == W_DATA);
  assign m_axi_bready  = (state == W_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state == R_ADDR);
  assign m_axi_rready  = (state == R_DATA) && !user_stall_r_data;

  assign user_stall_w_data = !((state == W_DATA) && m_axi_wready);
  assign user_data_out     = data_out_q;
  assign user_data_out_en  = data_out_en_q;
  assign user_free         = (state == IDLE);
  assign user_status       = (state == IDLE) ? status_q : 2'b01;

endmodule

// File: tb/tb_axi_burst_master_p.sv
// Directed testbench for axi_burst_master_p (default parameters: 32/64/8).
// The bench plays the AXI slave by hand and checks every user and AXI output.
module tb_axi_burst_master_p;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        user_start, user_w_r, user_stall_r_data;
  logic [31:0] user_addr_in;
  logic [7:0]  user_burst_len_in, user_data_strb;
  logic [63:0] user_data_in, user_data_out;
  logic        user_stall_w_data, user_data_out_en, user_free;
  logic [1:0]  user_status;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_wdata, m_axi_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] data_tbl [0:15];

  axi_burst_master_p dut (
    .aclk(aclk), .aresetn(aresetn),
    .user_start(user_start), .user_w_r(user_w_r), .user_addr_in(user_addr_in),
    .user_burst_len_in(user_burst_len_in), .user_data_strb(user_data_strb),
    .user_data_in(user_data_in), .user_stall_w_data(user_stall_w_data),
    .user_stall_r_data(user_stall_r_data), .user_data_out(user_data_out),
    .user_data_out_en(user_data_out_en), .user_free(user_free), .user_status(user_status),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write request; nseg=2 expects a page split with len0 beats-1 in segment 1.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] strb, input bit gaps,
                          input logic [1:0] bresp, input logic [1:0] exp_status,
                          input int nseg, input logic [7:0] len0);
    int b;
    int cyc;
    int seg_beat;
    bit seen;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    user_w_r = 1'b0; user_addr_in = addr; user_burst_len_in = len;
    user_data_strb = strb; user_data_in = data_tbl[0]; user_start = 1'b1;
    @(posedge aclk); #1 user_start = 1'b0;
    check("wr_busy_free", user_free, 0);
    check("wr_busy_status", user_status, 2'b01);
    b = 0;
    for (int s = 0; s < nseg; s++) begin
      exp_addr = (s == 0) ? addr : {addr[31:12] + 20'd1, 12'h000};
      exp_len  = (nseg == 1) ? len : ((s == 0) ? len0 : len - len0 - 8'd1);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (m_axi_awvalid) begin
          seen = 1'b1;
          check("awaddr", m_axi_awaddr, exp_addr);
          check("awlen", m_axi_awlen, exp_len);
          check("awsize", m_axi_awsize, 3'd3);
          check("awburst", m_axi_awburst, 2'b01);
          m_axi_awready = 1'b1;
          @(posedge aclk); #1 m_axi_awready = 1'b0;
        end else begin
          @(posedge aclk); #1;
        end
      end
      check("aw_handshake", seen, 1);
      seg_beat = 0; cyc = 0;
      while (seg_beat <= int'(exp_len) && cyc < 400) begin
        user_data_in = data_tbl[b];
        m_axi_wready = gaps ? !((cyc % 4 == 1) || (cyc % 7 == 3)) : 1'b1;
        #1;
        check("w_stall", user_stall_w_data, !m_axi_wready);
        check("wvalid", m_axi_wvalid, 1);
        if (m_axi_wready) begin
          check("wdata", m_axi_wdata, data_tbl[b]);
          check("wstrb", m_axi_wstrb, strb);
          check("wlast", m_axi_wlast, seg_beat == int'(exp_len));
          b++; seg_beat++;
        end
        @(posedge aclk); #1; cyc++;
      end
      m_axi_wready = 1'b0;
      check("w_beats", seg_beat, int'(exp_len) + 1);
      m_axi_bresp  = (s == nseg - 1) ? bresp : 2'b00;
      m_axi_bvalid = 1'b1;
      #1 check("bready", m_axi_bready, 1);
      @(posedge aclk); #1 m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    end
    check("wr_status", user_status, exp_status);
    check("wr_free", user_free, 1);
  endtask

  // One read request; the slave returns data_tbl, SLVERR on beat err_beat.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit stall_en,
                         input int err_beat, input logic [1:0] exp_status);
    int rb;
    int cyc;
    int pulses;
    bit prev_hs;
    bit seen;
    user_w_r = 1'b1; user_addr_in = addr; user_burst_len_in = len; user_start = 1'b1;
    @(posedge aclk); #1 user_start = 1'b0;
    check("rd_busy_free", user_free, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (m_axi_arvalid) begin
        seen = 1'b1;
        check("araddr", m_axi_araddr, addr);
        check("arlen", m_axi_arlen, len);
        check("arsize", m_axi_arsize, 3'd3);
        check("arburst", m_axi_arburst, 2'b01);
        check("rd_no_aw", m_axi_awvalid, 0);
        m_axi_arready = 1'b1;
        @(posedge aclk); #1 m_axi_arready = 1'b0;
      end else begin
        @(posedge aclk); #1;
      end
    end
    check("ar_handshake", seen, 1);
    rb = 0; cyc = 0; pulses = 0; prev_hs = 1'b0;
    while ((rb <= int'(len) || prev_hs) && cyc < 400) begin
      check("r_en", user_data_out_en, prev_hs);
      if (user_data_out_en) pulses++;
      if (prev_hs) check("r_data", user_data_out, data_tbl[rb-1]);
      m_axi_rvalid = (rb <= int'(len));
      m_axi_rdata  = data_tbl[rb % 16];
      m_axi_rlast  = (rb == int'(len));
      m_axi_rresp  = (rb == err_beat) ? 2'b10 : 2'b00;
      user_stall_r_data = stall_en ? ((cyc / 3) % 2 == 1) : 1'b0;
      #1;
      check("rready", m_axi_rready, (rb <= int'(len)) && !user_stall_r_data);
      prev_hs = m_axi_rvalid && m_axi_rready;
      if (prev_hs) rb++;
      @(posedge aclk); #1; cyc++;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; user_stall_r_data = 1'b0;
    check("r_pulses", pulses, int'(len) + 1);
    check("rd_status", user_status, exp_status);
    check("rd_free", user_free, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0; user_start = 1'b0; user_w_r = 1'b0; user_stall_r_data = 1'b0;
    user_addr_in = '0; user_burst_len_in = '0; user_data_strb = '0; user_data_in = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_data_out", user_data_out, 0);
    check("rst_data_en", user_data_out_en, 0);
    check("rst_free", user_free, 1);
    check("rst_status", user_status, 2'b00);
    check("rst_stall", user_stall_w_data, 1);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single-beat write.
    data_tbl[0] = 64'h0000_0000_F8F4_F2F1;
    do_write(32'h1000_0000, 8'd0, 8'hFF, 1'b0, 2'b00, 2'b00, 1, 8'd0);

    // 16-beat write with irregular wready gaps, then read back with user stalls.
    for (int i = 0; i < 16; i++) data_tbl[i] = {32'hC0DE_0000 | 32'(i), 32'h1234_5600 | 32'(i)};
    do_write(32'h1000_0080, 8'd15, 8'hFF, 1'b1, 2'b00, 2'b00, 1, 8'd0);
    do_read(32'h1000_0080, 8'd15, 1'b1, -1, 2'b00);

    // Read with SLVERR on beat 3: every beat still delivered, status 10.
    do_read(32'h1000_0080, 8'd15, 1'b0, 3, 2'b10);

    // Write with SLVERR response; status held while idle.
    do_write(32'h1000_0400, 8'd3, 8'h0F, 1'b1, 2'b10, 2'b10, 1, 8'd0);
    repeat (3) @(posedge aclk);
    #1 check("status_held", user_status, 2'b10);

    // 4KB-crossing request.
`ifdef AXIBM_4K_SPLIT_EN
    do_write(32'h1000_0FC0, 8'd15, 8'hFF, 1'b1, 2'b00, 2'b00, 2, 8'd7);
`else
    user_w_r = 1'b0; user_addr_in = 32'h1000_0FC0; user_burst_len_in = 8'd15;
    user_data_strb = 8'hFF; user_start = 1'b1;
    @(posedge aclk); #1 user_start = 1'b0;
    check("rej_free", user_free, 1);
    check("rej_status", user_status, 2'b11);
    for (int c = 0; c < 4; c++) begin
      check("rej_no_aw", m_axi_awvalid, 0);
      check("rej_no_w", m_axi_wvalid, 0);
      @(posedge aclk); #1;
    end
    check("rej_status_held", user_status, 2'b11);
`endif

    // Reset in the middle of W_DATA; a start while busy is ignored first.
    user_w_r = 1'b0; user_addr_in = 32'h1000_0200; user_burst_len_in = 8'd15;
    user_data_strb = 8'hFF; user_start = 1'b1;
    @(posedge aclk); #1 user_start = 1'b0;
    m_axi_awready = 1'b1;
    @(posedge aclk); #1 m_axi_awready = 1'b0;
    check("mid_wvalid", m_axi_wvalid, 1);
    check("mid_stall", user_stall_w_data, 1);
    user_w_r = 1'b1; user_start = 1'b1;
    @(posedge aclk); #1 user_start = 1'b0;
    check("busy_start_wvalid", m_axi_wvalid, 1);
    check("busy_start_arvalid", m_axi_arvalid, 0);
    check("busy_start_status", user_status, 2'b01);
    aresetn = 1'b0;
    #1;
    check("abort_wvalid", m_axi_wvalid, 0);
    check("abort_awvalid", m_axi_awvalid, 0);
    check("abort_free", user_free, 1);
    check("abort_status", user_status, 2'b00);
    @(posedge aclk); #1;
    check("abort_edge_wvalid", m_axi_wvalid, 0);
    check("abort_edge_status", user_status, 2'b00);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Recovery after the abort.
    data_tbl[0] = 64'h0BAD_F00D_0000_0001;
    do_write(32'h1000_0000, 8'd0, 8'h01, 1'b0, 2'b00, 2'b00, 1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
